iobus_uart_tx: RTL and testbench



---
 rtl/iobus_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_iobus_uart_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// iobus_uart_tx
// Memory-mapped 8N1 UART transmitter on the CPU IOBUS. Bytes written to TXDATA
// queue in a small circular FIFO and are shifted out LSB first on TX. Frames
// sent from a non-empty FIFO follow each other with no idle gap.
//
// Register window (word offsets from BASE_ADDR, decoded on IOBUS_ADDR[31:2]):
//   +0x0 TXDATA  W: push IOBUS_OUT[7:0]              R: 0
//   +0x4 STATUS  R: {count[8:4], ovf, empty, full, busy}
//                W: bit3 = 1 clears the sticky overflow flag
//   +0x8 CTRL    R/W: bit0 irq_en
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   IOBUS_ADDR   byte address from the CPU
//   IOBUS_OUT    write data from the CPU
//   IOBUS_WR     single-cycle write strobe
//   IOBUS_IN     read data, combinational from IOBUS_ADDR
//   TX           registered serial output, idle high
//   IRQ          registered level interrupt: enabled, FIFO empty, line idle
// -----------------------------------------------------------------------------
module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(CLKS_PER_BIT);

  localparam logic [29:0]      WORD_TXDATA = BASE_ADDR[31:2];
  localparam logic [29:0]      WORD_STATUS = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0]      WORD_CTRL   = BASE_ADDR[31:2] + 30'd2;
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Bus decode
  logic sel_txdata_s;
  logic sel_status_s;
  logic sel_ctrl_s;
  logic push_s;
  logic ovf_clr_s;
  logic ctrl_wr_s;

  // FIFO
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] fifo_cnt_r;
  logic [4:0]       fifo_cnt5_s;
  logic             empty_s;
  logic             full_s;
  logic             accept_s;
  logic             drop_s;
  logic [7:0]       head_s;

  // Transmitter
  state_t           state_r;
  state_t           state_next_s;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [BIT_W-1:0] bit_cnt_next_s;
  logic [2:0]       data_idx_r;
  logic [2:0]       data_idx_next_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_next_s;
  logic             bit_done_s;
  logic             pop_s;
  logic             tx_next_s;
  logic             tx_r;

  // Control / status
  logic             ovf_r;
  logic             irq_en_r;
  logic             irq_r;
  logic             busy_s;

  // Address decode, write strobes and FIFO occupancy flags
  always_comb begin
    sel_txdata_s = (IOBUS_ADDR[31:2] == WORD_TXDATA);
    sel_status_s = (IOBUS_ADDR[31:2] == WORD_STATUS);
    sel_ctrl_s   = (IOBUS_ADDR[31:2] == WORD_CTRL);
    push_s       = IOBUS_WR & sel_txdata_s;
    ovf_clr_s    = IOBUS_WR & sel_status_s & IOBUS_OUT[3];
    ctrl_wr_s    = IOBUS_WR & sel_ctrl_s;
    empty_s      = (fifo_cnt_r == {CNT_W{1'b0}});
    full_s       = (fifo_cnt_r == CNT_FULL);
    head_s       = fifo_mem_r[rd_ptr_r];
    fifo_cnt5_s  = 5'(fifo_cnt_r);
    busy_s       = (state_r != ST_IDLE);
  end

  // Push acceptance: a full FIFO still takes a byte when a pop frees the slot
  // in the same cycle (write and read pointers coincide, old head is read
  // combinationally before the edge overwrites it).
  always_comb begin
    accept_s = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      fifo_mem_r[wr_ptr_r] <= IOBUS_OUT[7:0];
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   fifo_cnt_r <= fifo_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Transmitter next-state logic; TX is derived from the next state so the
  // registered pin changes on the same edge as the state it belongs to.
  always_comb begin
    state_next_s    = state_r;
    bit_cnt_next_s  = bit_cnt_r;
    data_idx_next_s = data_idx_r;
    shift_next_s    = shift_r;
    pop_s           = 1'b0;
    bit_done_s      = (bit_cnt_r == BIT_LAST);

    case (state_r)
      ST_IDLE: begin
        bit_cnt_next_s = {BIT_W{1'b0}};
        if (!empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = head_s;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_next_s    = ST_DATA;
          bit_cnt_next_s  = {BIT_W{1'b0}};
          data_idx_next_s = 3'd0;
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          bit_cnt_next_s = {BIT_W{1'b0}};
          shift_next_s   = {1'b0, shift_r[7:1]};
          if (data_idx_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            data_idx_next_s = data_idx_r + 3'd1;
          end
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          bit_cnt_next_s = {BIT_W{1'b0}};
          // Chain straight into the next start bit when more data waits
          if (!empty_s) begin
            pop_s        = 1'b1;
            shift_next_s = head_s;
            state_next_s = ST_START;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        bit_cnt_next_s = {BIT_W{1'b0}};
      end
    endcase

    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = shift_next_s[0];
      default:  tx_next_s = 1'b1;
    endcase
  end

  // Transmitter state, counters, shift register and the TX pin
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= {BIT_W{1'b0}};
      data_idx_r <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      data_idx_r <= data_idx_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
    end
  end

  // Sticky overflow (a drop in the same cycle as a clear keeps it set) and irq_en
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_r    <= 1'b0;
      irq_en_r <= 1'b0;
    end else begin
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (ctrl_wr_s) begin
        irq_en_r <= IOBUS_OUT[0];
      end else begin
        irq_en_r <= irq_en_r;
      end
    end
  end

  // TX-idle interrupt, one cycle behind its condition
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_en_r & empty_s & (state_r == ST_IDLE);
    end
  end

  // Read mux; reflects registers after the latest edge, so a same-cycle push
  // is not yet visible in the count
  always_comb begin
    IOBUS_IN = 32'd0;
    if (sel_status_s) begin
      IOBUS_IN = {23'd0, fifo_cnt5_s, ovf_r, empty_s, full_s, busy_s};
    end else if (sel_ctrl_s) begin
      IOBUS_IN = {31'd0, irq_en_r};
    end else begin
      IOBUS_IN = 32'd0;
    end
  end

  assign TX  = tx_r;
  assign IRQ = irq_r;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// Bench for iobus_uart_tx. A frame-level reference model (byte queue plus a
// position within the current 10-bit frame) predicts TX, IRQ and every read of
// the register window; a compare process checks them each cycle at the falling
// edge. Directed sections pin the model with hand-computed values, then a
// randomized phase exercises fill, overflow, clears and control writes.
// -----------------------------------------------------------------------------
module tb_iobus_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam logic [29:0] W_TX  = BASE[31:2];
  localparam logic [29:0] W_ST  = BASE[31:2] + 30'd1;
  localparam logic [29:0] W_CT  = BASE[31:2] + 30'd2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  = BASE + 32'd4;
  logic [31:0] wdata = 32'd0;
  logic        wr    = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iobus_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .IOBUS_ADDR(addr),
    .IOBUS_OUT (wdata),
    .IOBUS_WR  (wr),
    .IOBUS_IN  (rdata),
    .TX        (tx),
    .IRQ       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'd0;
  bit         m_ovf    = 1'b0;
  bit         m_irq_en = 1'b0;
  bit         m_irq    = 1'b0;
  bit         m_tx     = 1'b1;

  always @(posedge clk or negedge rst_n) begin : model
    int         pre;
    bit         popped;
    bit         irq_nx;
    logic [9:0] frame;
    if (!rst_n) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_irq_en = 1'b0;
      m_irq    = 1'b0;
      m_tx     = 1'b1;
    end else begin
      pre    = q.size();
      irq_nx = m_irq_en && (pre == 0) && !m_active;
      popped = 1'b0;
      if (m_active) begin
        m_pos = m_pos + 1;
        if (m_pos == 10 * CPB) m_active = 1'b0;
      end
      if (!m_active && pre > 0) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
        popped   = 1'b1;
      end
      if (wr) begin
        if (addr[31:2] == W_TX) begin
          if (pre < DEPTH || popped) q.push_back(wdata[7:0]);
          else m_ovf = 1'b1;
        end else if (addr[31:2] == W_ST) begin
          if (wdata[3]) m_ovf = 1'b0;
        end else if (addr[31:2] == W_CT) begin
          m_irq_en = wdata[0];
        end
      end
      m_irq = irq_nx;
      frame = {1'b1, m_cur, 1'b0};
      m_tx  = m_active ? frame[m_pos / CPB] : 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int n;
    n = q.size();
    if (a[31:2] == W_ST)
      return {23'd0, 5'(n), m_ovf, (n == 0), (n == DEPTH), m_active};
    else if (a[31:2] == W_CT)
      return {31'd0, m_irq_en};
    else
      return 32'd0;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("tx", {31'd0, tx}, {31'd0, m_tx});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("rdata", rdata, exp_rd(addr));
  end

  // ---------------- drivers ----------------
  task automatic idle_bus();
    wr    = 1'b0;
    addr  = BASE + 32'd4;
    wdata = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic burst(input int n, input logic [7:0] first);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      addr = BASE; wdata = {24'd0, first + 8'(i)}; wr = 1'b1;
      @(posedge clk); #1;
    end
    idle_bus();
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (rdata[0] == 1'b0 && rdata[2] == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] a5_frame = 10'b11_0100_1010;  // start, A5 LSB first, stop
  initial begin
    int busy_run;
    bit ended;
    int r;
    int rate;

    idle_bus();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_status", rdata, 32'h0000_0004);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_status", rdata, 32'h0000_0004);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    // Single 0xA5 frame, hand-computed waveform
    bus_write(BASE, 32'h0000_00A5);
    @(posedge clk);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      check("a5_bit", {31'd0, tx}, {31'd0, a5_frame[i / CPB]});
      check("a5_busy", {31'd0, rdata[0]}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    check("a5_done_busy", {31'd0, rdata[0]}, 32'd0);

    // Three back-to-back bytes: one unbroken busy run
    burst(3, 8'h01);
    busy_run = 0;
    ended    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdata[0]) busy_run = busy_run + 1;
      else begin
        ended = 1'b1;
        break;
      end
    end
    check("burst3_ended", {31'd0, ended}, 32'd1);
    check("burst3_busy_run", busy_run, 32'd119);

    // Overflow: 10 bytes while the line is idle, last one dropped
    burst(10, 8'h10);
    @(negedge clk);
    check("ovf_status", rdata, 32'h0000_008B);
    bus_write(BASE + 32'd4, 32'h0000_0008);
    @(negedge clk);
    check("ovf_cleared", rdata, 32'h0000_0083);
    wait_idle(9 * 10 * CPB + 40);

    // Interrupt behaviour
    bus_write(BASE + 32'd8, 32'd1);
    @(negedge clk);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    bus_write(BASE, 32'h0000_005A);
    @(negedge clk);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_drop", {31'd0, irq}, 32'd0);
    wait_idle(10 * CPB + 20);
    check("irq_idle_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_reassert", {31'd0, irq}, 32'd1);

    // Randomized traffic: a heavy phase then a light phase
    for (int it = 0; it < 2000; it++) begin
      @(posedge clk); #1;
      rate = (it < 1000) ? 20 : 2;
      r = $urandom_range(0, 99);
      if (r < rate) begin
        addr = BASE; wdata = $urandom(); wr = 1'b1;
      end else if (r < rate + 3) begin
        addr = BASE + 32'd4; wdata = $urandom(); wr = 1'b1;
      end else if (r < rate + 5) begin
        addr = BASE + 32'd8; wdata = $urandom(); wr = 1'b1;
      end else if (r < rate + 10) begin
        case ($urandom_range(0, 3))
          0:       addr = BASE;
          1:       addr = BASE + 32'd8;
          2:       addr = BASE + 32'd6;
          default: addr = $urandom();
        endcase
        wdata = 32'd0; wr = 1'b0;
      end else begin
        idle_bus();
      end
    end
    idle_bus();
    wait_idle((DEPTH + 1) * 10 * CPB + 40);

    // Reset in the middle of the data bits
    bus_write(BASE, 32'h0000_00C3);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_status", rdata, 32'h0000_0004);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_write(BASE, 32'h0000_003C);
    wait_idle(10 * CPB + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
